// File: rtl/stopwatch_pkg.sv
// Shared types and default timing constants for the stopwatch key path.
// Defaults assume CLK_50: 10 ms debounce window, 1 s long-press.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } key_state_t;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int LONG_CYCLES_DEFAULT     = 50000000;

endpackage

// File: rtl/stopwatch_key_conditioner_if.sv
// Key bundle between the board pins and the stopwatch.
// master drives raw pins; slave is the conditioner.
interface stopwatch_key_conditioner_if #(
    parameter int NUM_KEYS = 2
);

    logic [NUM_KEYS-1:0] key_raw_n;
    logic [NUM_KEYS-1:0] key_clean_n;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic [NUM_KEYS-1:0] long_press;

    modport master (
        output key_raw_n,
        input  key_clean_n,
        input  press_pulse,
        input  release_pulse,
        input  long_press
    );

    modport slave (
        input  key_raw_n,
        output key_clean_n,
        output press_pulse,
        output release_pulse,
        output long_press
    );

endinterface

// File: rtl/stopwatch_key_debounce.sv
// One key channel: 2-flop synchroniser, debounce FSM, long-press timer.
// All outputs are registered; pulses last exactly one clock.
module stopwatch_key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_raw_n,
    output logic o_key_clean_n,
    output logic o_press_pulse,
    output logic o_release_pulse,
    output logic o_long_press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int LG_W = $clog2(LONG_CYCLES);

    // Entry cycle is the first stable sample, so the window closes at D-2.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    key_state_t      r_state;
    logic [DB_W-1:0] r_db_cnt;
    logic [LG_W-1:0] r_lg_cnt;
    logic            r_lg_fired;
    logic            r_clean_n;
    logic            r_press;
    logic            r_release;
    logic            r_long;

    key_state_t      w_state_nxt;
    logic [DB_W-1:0] w_db_cnt_nxt;
    logic [LG_W-1:0] w_lg_cnt_nxt;
    logic            w_lg_fired_nxt;
    logic            w_clean_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic            w_long_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= RELEASED;
            r_db_cnt   <= '0;
            r_lg_cnt   <= '0;
            r_lg_fired <= 1'b0;
            r_clean_n  <= 1'b1;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
        end else begin
            r_sync1    <= i_key_raw_n;
            r_sync2    <= r_sync1;
            r_state    <= w_state_nxt;
            r_db_cnt   <= w_db_cnt_nxt;
            r_lg_cnt   <= w_lg_cnt_nxt;
            r_lg_fired <= w_lg_fired_nxt;
            r_clean_n  <= w_clean_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_db_cnt_nxt   = r_db_cnt;
        w_lg_cnt_nxt   = r_lg_cnt;
        w_lg_fired_nxt = r_lg_fired;
        w_clean_nxt    = r_clean_n;
        w_press_nxt    = 1'b0;
        w_release_nxt  = 1'b0;
        w_long_nxt     = 1'b0;
        unique case (r_state)
            RELEASED: begin
                if (!r_sync2) begin
                    w_state_nxt  = PRESS_PEND;
                    w_db_cnt_nxt = '0;
                end
            end
            PRESS_PEND: begin
                if (r_sync2) begin
                    w_state_nxt  = RELEASED;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt  = PRESSED;
                    w_db_cnt_nxt = '0;
                    w_clean_nxt  = 1'b0;
                    w_press_nxt  = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            PRESSED: begin
                // Fired flag stops the saturated count from re-pulsing.
                if (!r_lg_fired) begin
                    if (r_lg_cnt == LG_LAST) begin
                        w_long_nxt     = 1'b1;
                        w_lg_fired_nxt = 1'b1;
                    end else begin
                        w_lg_cnt_nxt = r_lg_cnt + LG_W'(1);
                    end
                end
                if (r_sync2) begin
                    w_state_nxt  = RELEASE_PEND;
                    w_db_cnt_nxt = '0;
                end
            end
            RELEASE_PEND: begin
                if (!r_sync2) begin
                    w_state_nxt  = PRESSED;
                    w_db_cnt_nxt = '0;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nxt    = RELEASED;
                    w_db_cnt_nxt   = '0;
                    w_lg_cnt_nxt   = '0;
                    w_lg_fired_nxt = 1'b0;
                    w_clean_nxt    = 1'b1;
                    w_release_nxt  = 1'b1;
                end else begin
                    w_db_cnt_nxt = r_db_cnt + DB_W'(1);
                end
            end
            default: begin
                w_state_nxt  = RELEASED;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    assign o_key_clean_n   = r_clean_n;
    assign o_press_pulse   = r_press;
    assign o_release_pulse = r_release;
    assign o_long_press    = r_long;

endmodule

// File: rtl/stopwatch_key_conditioner.sv
// Conditions the stopwatch push-buttons (bit 0 start_stop, bit 1 hold).
// One independent debounce channel per key.
module stopwatch_key_conditioner
    import stopwatch_pkg::*;
#(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
    input  logic                        CLK_50,
    input  logic                        reset_n,
    stopwatch_key_conditioner_if.slave  keys
);

    logic [NUM_KEYS-1:0] w_clean_n;
    logic [NUM_KEYS-1:0] w_press;
    logic [NUM_KEYS-1:0] w_release;
    logic [NUM_KEYS-1:0] w_long;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        stopwatch_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_key (
            .i_clk           (CLK_50),
            .i_rst_n         (reset_n),
            .i_key_raw_n     (keys.key_raw_n[g]),
            .o_key_clean_n   (w_clean_n[g]),
            .o_press_pulse   (w_press[g]),
            .o_release_pulse (w_release[g]),
            .o_long_press    (w_long[g])
        );
    end

    assign keys.key_clean_n   = w_clean_n;
    assign keys.press_pulse   = w_press;
    assign keys.release_pulse = w_release;
    assign keys.long_press    = w_long;

endmodule

// File: tb/tb_stopwatch_key_conditioner.sv
// Directed bench for stopwatch_key_conditioner (DEBOUNCE=4, LONG=20).
// Output vector is {key_clean_n, press_pulse, release_pulse, long_press}.
module tb_stopwatch_key_conditioner;

    localparam logic [7:0] IDLE = 8'b11_00_00_00;
    localparam logic [7:0] H0   = 8'b10_00_00_00;
    localparam logic [7:0] P0   = 8'b10_01_00_00;
    localparam logic [7:0] R0   = 8'b11_00_01_00;
    localparam logic [7:0] L0   = 8'b10_00_00_01;
    localparam logic [7:0] H1   = 8'b01_00_00_00;
    localparam logic [7:0] P1   = 8'b01_10_00_00;
    localparam logic [7:0] R1   = 8'b11_00_10_00;
    localparam logic [7:0] HB   = 8'b00_00_00_00;
    localparam logic [7:0] PB   = 8'b00_11_00_00;
    localparam logic [7:0] RB   = 8'b11_00_11_00;

    logic CLK_50  = 1'b0;
    logic reset_n = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #10 CLK_50 = ~CLK_50;

    stopwatch_key_conditioner_if #(.NUM_KEYS(2)) kif ();

    stopwatch_key_conditioner #(
        .NUM_KEYS        (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20)
    ) dut (
        .CLK_50  (CLK_50),
        .reset_n (reset_n),
        .keys    (kif)
    );

    function automatic logic [7:0] outv();
        return {kif.key_clean_n, kif.press_pulse,
                kif.release_pulse, kif.long_press};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK_50);
        #1;
    endtask

    // n edges: all but the last must show idle, the last shows hit.
    task automatic expect_seq(input string tag, input int n,
                              input logic [7:0] idle,
                              input logic [7:0] hit);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk($sformatf("%s[%0d]", tag, i), outv(),
                (i == n) ? hit : idle);
        end
    endtask

    initial begin
        kif.key_raw_n = 2'b00;
        reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_vals", outv(), IDLE);

        reset_n = 1'b1;
        expect_seq("rst_hold", 6, IDLE, PB);
        expect_seq("both_held", 1, HB, HB);
        kif.key_raw_n = 2'b11;
        expect_seq("rel_both", 6, HB, RB);
        expect_seq("rel_both_end", 1, IDLE, IDLE);

        kif.key_raw_n = 2'b10;
        expect_seq("press0", 6, IDLE, P0);
        expect_seq("long0", 20, H0, L0);
        expect_seq("long0_once", 4, H0, H0);
        kif.key_raw_n = 2'b11;
        expect_seq("rel0", 6, H0, R0);
        expect_seq("rel0_end", 1, IDLE, IDLE);

        kif.key_raw_n = 2'b10;
        expect_seq("bnc_lo", 3, IDLE, IDLE);
        kif.key_raw_n = 2'b11;
        expect_seq("bnc_hi", 1, IDLE, IDLE);
        kif.key_raw_n = 2'b10;
        expect_seq("bnc_press", 6, IDLE, P0);
        kif.key_raw_n = 2'b11;
        expect_seq("bnc_rel", 6, H0, R0);

        kif.key_raw_n = 2'b01;
        expect_seq("short1", 6, IDLE, P1);
        expect_seq("short1_hold", 4, H1, H1);
        kif.key_raw_n = 2'b11;
        expect_seq("short1_rel", 6, H1, R1);
        expect_seq("short1_nolong", 20, IDLE, IDLE);

        kif.key_raw_n = 2'b10;
        expect_seq("pre_rst", 6, IDLE, P0);
        reset_n = 1'b0;
        #2;
        chk("rst_async_pressed", outv(), IDLE);
        expect_seq("rst_hold_pr", 2, IDLE, IDLE);
        reset_n = 1'b1;
        expect_seq("rst_repress", 6, IDLE, P0);
        kif.key_raw_n = 2'b11;
        expect_seq("rst_rel", 6, H0, R0);

        kif.key_raw_n = 2'b10;
        expect_seq("pend", 3, IDLE, IDLE);
        reset_n = 1'b0;
        #2;
        chk("rst_async_pend", outv(), IDLE);
        expect_seq("rst_hold_pend", 2, IDLE, IDLE);
        reset_n = 1'b1;
        expect_seq("pend_rst_press", 6, IDLE, P0);
        expect_seq("pend_rst_after", 1, H0, H0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
